// File: rtl/hack_rom_loader_if.sv
// Byte-source and instruction-memory write bundle for the Hack boot loader.
// The master modport is the loader; the slave modport is the byte host plus memory side.
interface hack_rom_loader_if #(
  parameter int ADDR_W = 15
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, rom_we, rom_addr, rom_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, rom_we, rom_addr, rom_wdata
  );
endinterface

// File: rtl/hack_rom_loader.sv
// Hack boot sequencer: holds the cpu in reset, streams a byte image into instruction memory, then releases it.
// Define LOADER_CHECKSUM_EN to require a trailing 16-bit word-sum checksum before the cpu is released.
module hack_rom_loader #(
  parameter int ADDR_W = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  hack_rom_loader_if.master bus,
  output logic              cpu_rst_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE, HI, LO, WR, RUN
`ifdef LOADER_CHECKSUM_EN
    , CHI, CLO
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [15:0]       word_q, word_d;
  logic              err_q, err_d;
  logic              rom_we_q, rom_we_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              byte_ready;
  logic              hs;
  logic              last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]       sum_q, sum_d;
  logic [7:0]        chk_hi_q, chk_hi_d;
`endif

`ifdef LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == HI) || (state_q == LO) || (state_q == CHI) || (state_q == CLO);
`else
  assign byte_ready = (state_q == HI) || (state_q == LO);
`endif
  assign hs        = bus.byte_valid & byte_ready;
  assign last_word = ({1'b0, cnt_q} == (len_q - (ADDR_W+1)'(1)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    word_d   = word_q;
    err_d    = err_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d    = sum_q;
    chk_hi_d = chk_hi_q;
`endif
    unique case (state_q)
      IDLE, RUN: begin
        if (start_i) begin
          if (len_i == '0) begin
            err_d   = 1'b0;
            state_d = RUN;
          end else if (len_i <= MAX_LEN) begin
            len_d   = len_i;
            cnt_d   = '0;
            err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
            state_d = HI;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      HI: begin
        if (hs) begin
          word_d  = {bus.byte_data, word_q[7:0]};
          state_d = LO;
        end
      end
      LO: begin
        if (hs) begin
          word_d  = {word_q[15:8], bus.byte_data};
          state_d = WR;
        end
      end
      WR: begin
`ifdef LOADER_CHECKSUM_EN
        sum_d = sum_q + word_q;
`endif
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHI;
`else
          state_d = RUN;
`endif
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          state_d = HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHI: begin
        if (hs) begin
          chk_hi_d = bus.byte_data;
          state_d  = CLO;
        end
      end
      CLO: begin
        if (hs) begin
          if ({chk_hi_q, bus.byte_data} == sum_q) begin
            state_d = RUN;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state so they line up with it
    rom_we_d = (state_d == WR);
    run_d    = (state_d == RUN);
    busy_d   = (state_d != IDLE) && (state_d != RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      word_q   <= '0;
      err_q    <= 1'b0;
      rom_we_q <= 1'b0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q    <= '0;
      chk_hi_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      word_q   <= word_d;
      err_q    <= err_d;
      rom_we_q <= rom_we_d;
      run_q    <= run_d;
      busy_q   <= busy_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
      chk_hi_q <= chk_hi_d;
`endif
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.rom_we     = rom_we_q;
  assign bus.rom_addr   = cnt_q;
  assign bus.rom_wdata  = word_q;
  assign cpu_rst_n_o    = run_q;
  assign done_o         = run_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;
endmodule

// File: tb/tb_hack_rom_loader.sv
// Self-checking bench for hack_rom_loader: random byte images and handshake patterns against a word-queue model.
module tb_hack_rom_loader;
  localparam int ADDR_W = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [ADDR_W:0] len;
  logic            cpu_rst_n, busy, done, err;

  hack_rom_loader_if #(.ADDR_W(ADDR_W)) bus ();

  hack_rom_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .len_i      (len),
    .bus        (bus),
    .cpu_rst_n_o(cpu_rst_n),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          vmode   = 0;
  int          prev_we = 0;
  int          we_cnt  = 0;
  int          last_we = 0;
  logic        hs_pend = 1'b0;
  logic        tog     = 1'b0;
  logic [7:0]  src_q[$];
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // byte source: pops a byte for every handshake seen, then re-presents the head of the queue
  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    forever begin
      @(posedge clk);
      cyc++;
      if (hs_pend && src_q.size() > 0) void'(src_q.pop_front());
      #1;
      tog = ~tog;
      if (src_q.size() > 0 && (vmode == 0 || (vmode == 1 && tog) ||
                               (vmode == 2 && $urandom_range(0, 1) == 1))) begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = src_q[0];
      end else begin
        bus.byte_valid = 1'b0;
      end
    end
  end

  // memory-side monitor: every write must match the head of the expected word queue
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      hs_pend = bus.byte_valid && bus.byte_ready && !rst;
      if (!rst) begin
        if (bus.rom_we) begin
          if (exp_q.size() == 0) begin
            check("spurious_we", 32'(bus.rom_we), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("we_addr", 32'(bus.rom_addr), {16'd0, e[31:16]});
            check("we_data", 32'(bus.rom_wdata), {16'd0, e[15:0]});
          end
          if (vmode == 0 && we_cnt > 0) check("we_gap", 32'(cyc - prev_we), 32'd3);
          prev_we = cyc;
          last_we = cyc;
          we_cnt++;
        end
        if (bus.byte_ready) begin
          check("ready_busy", 32'(busy), 32'd1);
          check("ready_no_we", 32'(bus.rom_we), 32'd0);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [ADDR_W:0] l);
    @(posedge clk);
    #1;
    start = 1'b1;
    len   = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] words[$], input int mode, input bit bad_chk, input bit glitch);
    int          n;
    logic [15:0] sum;
    n     = words.size();
    sum   = 16'h0000;
    vmode = mode;
    we_cnt = 0;
    for (int i = 0; i < n; i++) begin
      src_q.push_back(words[i][15:8]);
      src_q.push_back(words[i][7:0]);
      exp_q.push_back({16'(i), words[i]});
      sum = sum + words[i];
    end
`ifdef LOADER_CHECKSUM_EN
    if (n > 0) begin
      sum = sum + 16'(bad_chk);
      src_q.push_back(sum[15:8]);
      src_q.push_back(sum[7:0]);
    end
`endif
    pulse_start((ADDR_W+1)'(n));
    if (glitch) pulse_start((ADDR_W+1)'($urandom_range(1, 8)));
    for (int c = 0; c < n * 40 + 100; c++) begin
      if (done || err) break;
      @(negedge clk);
    end
    if (bad_chk) begin
      check("chk_err", 32'(err), 32'd1);
      check("chk_cpu", 32'(cpu_rst_n), 32'd0);
      check("chk_done", 32'(done), 32'd0);
    end else begin
      check("load_done", 32'(done), 32'd1);
      check("load_cpu", 32'(cpu_rst_n), 32'd1);
      check("load_err", 32'(err), 32'd0);
`ifndef LOADER_CHECKSUM_EN
      if (n > 0) check("release_lat", 32'(cyc - last_we), 32'd1);
`endif
    end
    check("busy_end", 32'(busy), 32'd0);
    check("words_left", 32'(exp_q.size()), 32'd0);
    check("bytes_left", 32'(src_q.size()), 32'd0);
    src_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] wq[$];
    bit          seen;
    rst   = 1'b1;
    start = 1'b0;
    len   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_cpu", 32'(cpu_rst_n), 32'd0);
      check("idle_we", 32'(bus.rom_we), 32'd0);
      check("idle_ready", 32'(bus.byte_ready), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      if (i == 0) begin
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_wdata", 32'(bus.rom_wdata), 32'd0);
      end
    end

    wq = '{16'h0005, 16'hEC10, 16'hE308};
    do_load(wq, 0, 1'b0, 1'b0);
    do_load(wq, 1, 1'b0, 1'b0);

    // reset in the middle of a two-word load
    wq = '{16'($urandom), 16'($urandom)};
    vmode = 0;
    we_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      src_q.push_back(wq[i][15:8]);
      src_q.push_back(wq[i][7:0]);
      exp_q.push_back({16'(i), wq[i]});
    end
    pulse_start(17'(2) & {(ADDR_W+1){1'b1}});
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (exp_q.size() < 2) begin
        seen = 1'b1;
        break;
      end
    end
    check("mid_first_word", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_cpu", 32'(cpu_rst_n), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(bus.byte_ready), 32'd0);
    check("mid_rst_we", 32'(bus.rom_we), 32'd0);
    @(negedge clk);
    src_q.delete();
    exp_q.delete();
    repeat (8) @(negedge clk);
    wq = '{16'($urandom)};
    do_load(wq, 2, 1'b0, 1'b0);

    // oversize length, then zero length
    pulse_start((ADDR_W+1)'(17'h8001));
    @(negedge clk);
    check("big_err", 32'(err), 32'd1);
    check("big_busy", 32'(busy), 32'd0);
    check("big_cpu", 32'(cpu_rst_n), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("big_ready", 32'(bus.byte_ready), 32'd0);
    end
    pulse_start('0);
    @(negedge clk);
    check("zero_err", 32'(err), 32'd0);
    check("zero_cpu", 32'(cpu_rst_n), 32'd1);
    check("zero_done", 32'(done), 32'd1);

    // largest legal length is accepted; abort it with rst
    pulse_start({1'b1, {ADDR_W{1'b0}}});
    @(negedge clk);
    check("max_busy", 32'(busy), 32'd1);
    check("max_err", 32'(err), 32'd0);
    check("max_cpu", 32'(cpu_rst_n), 32'd0);
    check("max_ready", 32'(bus.byte_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("max_rst_busy", 32'(busy), 32'd0);

    // a start during a load must be ignored
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(16'($urandom));
    do_load(wq, 0, 1'b0, 1'b1);

    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(0, 6);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
      do_load(wq, $urandom_range(0, 2), 1'b0, 1'b0);
    end

`ifdef LOADER_CHECKSUM_EN
    wq = '{16'h1234, 16'h0001};
    do_load(wq, 0, 1'b0, 1'b0);
    do_load(wq, 0, 1'b1, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
